// File: rtl/wb_led_walker.sv
// Wishbone slave that sweeps one lit LED across NLEDS outputs at a programmable step rate.
// Acks each accepted request one cycle later; CTRL/DIV writes stall while a walk is running.
module wb_led_walker #(
  parameter int          NLEDS   = 8,
  parameter logic [31:0] CLK_DIV = 32'd12_000_000
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_cyc,
  input  logic             i_stb,
  input  logic             i_we,
  input  logic [1:0]       i_addr,
  input  logic [31:0]      i_data,
  output logic             o_stall,
  output logic             o_ack,
  output logic [31:0]      o_data,
  output logic [NLEDS-1:0] o_led
);

  localparam int            PW   = $clog2(NLEDS);
  localparam logic [PW-1:0] LAST = PW'(NLEDS - 1);

  // IDLE means not busy; UP/DOWN is the current sweep direction.
  typedef enum logic [1:0] {IDLE, UP, DOWN} state_t;

  state_t        state, state_n;
  logic [PW-1:0] pos, pos_n;
  logic [7:0]    passes, passes_n;
  logic [31:0]   cnt, cnt_n;
  logic [31:0]   div, div_n;
  logic [1:0]    mode, mode_n;
  logic [7:0]    rep, rep_n;
  logic          busy, accept, step, oneway, cont;
  logic [7:0]    pos8;
  logic [31:0]   rdata;

  assign busy    = (state != IDLE);
  assign o_stall = busy && i_we && (i_addr == 2'd0 || i_addr == 2'd1);
  assign accept  = i_cyc && i_stb && !o_stall;
  assign oneway  = (mode == 2'd1);
  assign cont    = (mode == 2'd2);
  assign pos8    = 8'(pos);
  assign o_led   = busy ? (NLEDS'(1) << pos) : '0;

  always_comb begin
    rdata = '0;
    case (i_addr)
      2'd0:    rdata = {22'd0, mode, rep};
      2'd1:    rdata = div;
      2'd2:    rdata = {busy, 7'd0, passes, 8'd0, pos8};
      default: rdata = '0;
    endcase
  end

  always_comb begin
    state_n  = state;
    pos_n    = pos;
    passes_n = passes;
    cnt_n    = cnt;
    div_n    = div;
    mode_n   = mode;
    rep_n    = rep;
    step     = busy && (cnt == 32'd0);

    if (busy) cnt_n = step ? div - 32'd1 : cnt - 32'd1;

    if (step) begin
      case (state)
        UP: begin
          if (pos != LAST) begin
            pos_n = pos + PW'(1);
          end else if (oneway) begin
            if (passes > 8'd1) begin
              pos_n    = '0;
              passes_n = passes - 8'd1;
            end else begin
              state_n  = IDLE;
              pos_n    = '0;
              passes_n = '0;
            end
          end else begin
            state_n = DOWN;
            pos_n   = pos - PW'(1);
          end
        end
        DOWN: begin
          if (pos != '0) begin
            pos_n = pos - PW'(1);
          end else if (cont) begin
            state_n = UP;
            pos_n   = PW'(1);
          end else if (passes > 8'd1) begin
            // Bounce passes restart at 0, so position 0 is held across the boundary.
            state_n  = UP;
            passes_n = passes - 8'd1;
          end else begin
            state_n  = IDLE;
            passes_n = '0;
          end
        end
        default: ;
      endcase
    end

    if (accept && i_we) begin
      case (i_addr)
        2'd0: begin
          mode_n   = i_data[9:8];
          rep_n    = i_data[7:0];
          state_n  = UP;
          pos_n    = '0;
          cnt_n    = div - 32'd1;
          if (i_data[9:8] == 2'd2)
            passes_n = '0;
          else
            passes_n = (i_data[7:0] == 8'd0) ? 8'd1 : i_data[7:0];
        end
        2'd1:    div_n = (i_data == 32'd0) ? 32'd1 : i_data;
        2'd3: begin
          state_n  = IDLE;
          pos_n    = '0;
          passes_n = '0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state  <= IDLE;
      pos    <= '0;
      passes <= '0;
      cnt    <= CLK_DIV - 32'd1;
      div    <= CLK_DIV;
      mode   <= '0;
      rep    <= '0;
      o_ack  <= 1'b0;
      o_data <= '0;
    end else begin
      state  <= state_n;
      pos    <= pos_n;
      passes <= passes_n;
      cnt    <= cnt_n;
      div    <= div_n;
      mode   <= mode_n;
      rep    <= rep_n;
      o_ack  <= accept;
      if (accept) o_data <= rdata;
    end
  end

endmodule

// File: tb/tb_wb_led_walker.sv
// Bench for wb_led_walker: closed-form walk model plus literal sequences and randomized bus traffic.
module tb_wb_led_walker;
  localparam int N    = 4;
  localparam int CDIV = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [1:0]    addr = 2'd0;
  logic [31:0]   wdat = 32'd0;
  logic          stall, ack;
  logic [31:0]   rdat;
  logic [N-1:0]  led;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_led_walker #(.NLEDS(N), .CLK_DIV(32'(CDIV))) dut (
    .i_clk(clk), .i_reset(rst), .i_cyc(cyc), .i_stb(stb), .i_we(we),
    .i_addr(addr), .i_data(wdat), .o_stall(stall), .o_ack(ack),
    .o_data(rdat), .o_led(led)
  );

  // Model: a walk is described only by cycles elapsed since its start.
  bit          m_busy, m_ack, m_rd;
  int          m_k, m_div, m_wdiv, m_mode, m_rep;
  logic [31:0] m_data;

  function automatic int eff_mode();
    return (m_mode == 3) ? 0 : m_mode;
  endfunction

  function automatic int plen(input int md);
    return (md == 1) ? N : 2 * N - 1;
  endfunction

  function automatic int reff();
    return (m_rep == 0) ? 1 : m_rep;
  endfunction

  function automatic int pos_of(input int md, input int i);
    int r;
    if (md == 1) return i % N;
    if (md == 2) begin
      r = i % (2 * N - 2);
      return (r < N) ? r : 2 * N - 2 - r;
    end
    r = i % (2 * N - 1);
    return (r < N) ? r : 2 * N - 2 - r;
  endfunction

  function automatic int cur_pos();
    if (!m_busy) return 0;
    return pos_of(eff_mode(), m_k / m_wdiv);
  endfunction

  function automatic int cur_passes();
    if (!m_busy || eff_mode() == 2) return 0;
    return reff() - (m_k / m_wdiv) / plen(eff_mode());
  endfunction

  function automatic logic [31:0] read_val(input logic [1:0] a);
    logic [31:0] v;
    v = '0;
    case (a)
      2'd0:    v = 32'(m_mode * 256 + m_rep);
      2'd1:    v = 32'(m_div);
      2'd2:    v = (m_busy ? 32'h8000_0000 : 32'h0) | 32'(cur_passes() * 65536) | 32'(cur_pos());
      default: v = '0;
    endcase
    return v;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_ack = 0; m_rd = 0; m_k = 0;
    m_div = CDIV; m_wdiv = CDIV; m_mode = 0; m_rep = 0; m_data = '0;
  endtask

  task automatic model_step();
    bit          acc;
    logic [31:0] rv;
    acc = cyc && stb && !(m_busy && we && addr < 2'd2);
    rv  = read_val(addr);
    m_ack = acc;
    m_rd  = acc && !we;
    if (acc && !we) m_data = rv;
    if (m_busy) begin
      m_k++;
      if (eff_mode() != 2 && m_k >= reff() * plen(eff_mode()) * m_wdiv) m_busy = 0;
    end
    if (acc && we) begin
      case (addr)
        2'd0: begin
          m_mode = int'(wdat[9:8]); m_rep = int'(wdat[7:0]);
          m_busy = 1; m_k = 0; m_wdiv = m_div;
        end
        2'd1:    m_div = (wdat == 32'd0) ? 1 : int'(wdat);
        2'd3:    m_busy = 0;
        default: ;
      endcase
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else model_step();
    end
  end

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", nm, got, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (!rst) begin
        check("led", 32'(led), m_busy ? (32'd1 << cur_pos()) : 32'd0);
        check("stall", 32'(stall), 32'(m_busy && we && addr < 2'd2));
        check("ack", 32'(ack), 32'(m_ack));
        if (m_ack && m_rd) check("rdata", rdat, m_data);
      end
    end
  end

  // Present one request at a negedge; return at the negedge where its ack is visible.
  task automatic bus(input logic w, input logic [1:0] a, input logic [31:0] d,
                     output logic [31:0] q, output int waited);
    logic st;
    int   n;
    cyc = 1'b1; stb = 1'b1; we = w; addr = a; wdat = d; n = 0; q = '0;
    forever begin
      #2 st = stall;
      @(negedge clk);
      if (!st) begin
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        q = rdat;
        break;
      end
      n++;
      if (n > 300) begin
        checks++; errors++;
        $display("FAIL bus_timeout addr %0d waited %0d limit 300", a, n);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        break;
      end
    end
    waited = n;
  endtask

  logic [31:0] q;
  int          wt;
  int          lit1 [22] = '{1,1,1,2,2,2,4,4,4,8,8,8,4,4,4,2,2,2,1,1,1,0};
  int          litc [8]  = '{1,2,4,8,4,2,1,2};
  int          lito [5]  = '{1,2,4,8,0};

  initial begin
    repeat (2) @(negedge clk);
    check("rst_led", 32'(led), 32'd0);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_data", rdat, 32'd0);
    rst = 1'b0;
    bus(1'b0, 2'd1, 0, q, wt); check("rst_div", q, 32'(CDIV));
    bus(1'b0, 2'd0, 0, q, wt); check("rst_ctrl", q, 32'd0);

    // Bounce R=1, DIV=3
    bus(1'b1, 2'd1, 32'd3, q, wt);
    bus(1'b1, 2'd0, 32'h001, q, wt);
    check("start_ack", 32'(ack), 32'd1);
    for (int i = 0; i < 22; i++) begin
      check("bounce_seq", 32'(led), 32'(lit1[i]));
      @(negedge clk);
    end

    // One-way R=2, DIV=2
    bus(1'b1, 2'd1, 32'd2, q, wt);
    bus(1'b1, 2'd0, 32'h102, q, wt);
    bus(1'b0, 2'd2, 0, q, wt); check("status_p2", q, 32'h8002_0000);
    repeat (8) @(negedge clk);
    bus(1'b0, 2'd2, 0, q, wt); check("status_p1", q, 32'h8001_0000);
    repeat (10) @(negedge clk);
    bus(1'b0, 2'd2, 0, q, wt); check("status_idle", q, 32'h0);

    // Start while busy stalls until the walk ends
    bus(1'b1, 2'd0, 32'h001, q, wt);
    bus(1'b1, 2'd0, 32'h101, q, wt); check("stall_cycles", 32'(wt), 32'd14);
    bus(1'b0, 2'd2, 0, q, wt); check("status_busy", 32'(q[31]), 32'd1);
    bus(1'b1, 2'd2, 32'hFFFF, q, wt); check("status_wr_nostall", 32'(wt), 32'd0);
    repeat (10) @(negedge clk);

    // Continuous, DIV=1, then abort
    bus(1'b1, 2'd1, 32'd1, q, wt);
    bus(1'b1, 2'd0, 32'h200, q, wt);
    for (int i = 0; i < 8; i++) begin
      check("cont_seq", 32'(led), 32'(litc[i]));
      @(negedge clk);
    end
    repeat (32) @(negedge clk);
    bus(1'b1, 2'd3, 0, q, wt);
    check("abort_led", 32'(led), 32'd0);
    check("abort_ack", 32'(ack), 32'd1);
    bus(1'b0, 2'd0, 0, q, wt); check("ctrl_kept", q, 32'h200);

    // DIV 0 stores 1; R=0 acts as 1
    bus(1'b1, 2'd1, 32'd0, q, wt);
    bus(1'b0, 2'd1, 0, q, wt); check("div0", q, 32'd1);
    bus(1'b1, 2'd0, 32'h100, q, wt);
    for (int i = 0; i < 5; i++) begin
      check("r0_seq", 32'(led), 32'(lito[i]));
      @(negedge clk);
    end

    // Randomized traffic
    for (int it = 0; it < 80; it++) begin
      int op;
      op = $urandom_range(0, 9);
      if ((op == 5 || op == 6 || op == 7) && m_busy && eff_mode() == 2) op = 4;
      case (op)
        0: begin
          cyc = 1'b0; stb = 1'b1; we = 1'b1; addr = 2'd0; wdat = 32'h001;
          @(negedge clk);
          stb = 1'b0; we = 1'b0;
        end
        1, 2: bus(1'b0, 2'($urandom_range(0, 3)), 0, q, wt);
        3: bus(1'b1, 2'd2, $urandom, q, wt);
        4: bus(1'b1, 2'd3, $urandom, q, wt);
        5: bus(1'b1, 2'd1, 32'($urandom_range(0, 3)), q, wt);
        6, 7: bus(1'b1, 2'd0, 32'($urandom_range(0, 3) * 256 + $urandom_range(0, 2)), q, wt);
        default: repeat ($urandom_range(0, 10)) @(negedge clk);
      endcase
    end
    bus(1'b1, 2'd3, 0, q, wt);

    // Asynchronous reset mid-walk, during an ack
    bus(1'b1, 2'd1, 32'd2, q, wt);
    bus(1'b1, 2'd0, 32'h003, q, wt);
    repeat (5) @(negedge clk);
    bus(1'b0, 2'd2, 0, q, wt);
    #2 rst = 1'b1;
    #1;
    check("arst_led", 32'(led), 32'd0);
    check("arst_ack", 32'(ack), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    bus(1'b0, 2'd1, 0, q, wt); check("arst_div", q, 32'(CDIV));
    bus(1'b0, 2'd2, 0, q, wt); check("arst_status", q, 32'd0);
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/wb_led_walker.md
# wb_led_walker

Parametrised Wishbone-controlled LED walker: on request, sweeps a single lit LED across `NLEDS` outputs at a programmable step rate. Supports bounce, one-way and continuous modes, a repeat count, run-time divider programming, abort and status readback. Sits as a pipelined Wishbone slave on the peripheral bus driving board LEDs.

## Interface
- `NLEDS`, 8: number of LEDs. Legal range 2..256.
- `CLK_DIV`, 12_000_000: reset value of the step divider, in clock cycles per step.
- `i_clk` in 1: system clock.
- `i_reset` in 1: asynchronous, active-high reset.
- `i_cyc` in 1: Wishbone cycle.
- `i_stb` in 1: Wishbone strobe.
- `i_we` in 1: write enable.
- `i_addr` in 2: register select.
- `i_data` in 32: write data.
- `o_stall` out 1: bus stall.
- `o_ack` out 1: bus acknowledge.
- `o_data` out 32: read data, valid with `o_ack`.
- `o_led` out NLEDS: LED drive, one-hot or zero.

## Operation
- Accept: `i_cyc && i_stb && !o_stall`. Every accepted request is acked exactly once, on the next cycle.
- Register map:
  - addr 0 CTRL: `[9:8]` mode, `[7:0]` repeat R. A write latches both fields and starts a walk.
  - addr 1 DIV: `[31:0]` step period. A write of 0 stores 1.
  - addr 2 STATUS: read-only. `[31]` busy, `[23:16]` passes remaining, `[7:0]` position. Writes are acked and ignored.
  - addr 3 ABORT: a write stops the walk. Reads return 0.
- Modes:
  - 0 BOUNCE: per pass, positions 0,1..N-1,N-2..0 (L = 2N-1).
  - 1 ONE-WAY: per pass, positions 0..N-1 (L = N).
  - 2 CONTINUOUS: bounce forever, R ignored.
  - 3 is reserved and behaves as 0.
- R = 0 is treated as 1. Passes are concatenated with no idle gap. In bounce mode, each pass restarts at position 0.
- Each position is held exactly DIV cycles. The walk ends after the final position's period, at which point busy clears and `o_led` returns to 0.
- Busy cycles per walk = R·L·DIV for modes 0/1.
- Step timing:
  - The divider counter reloads to DIV-1 on start and after each step.
  - A step occurs when the counter reaches 0 while busy.
- `o_led = busy ? (1 << pos) : 0`, derived from registered state only.
- Stall rule: `o_stall = busy && i_we && (i_addr == 0 || i_addr == 1)`. Reads, STATUS writes and ABORT never stall.
- CTRL read returns the last latched mode/R. DIV read returns the current divider.

## Timing
- Reset values:
  - `o_ack=0`, `o_data=0`, `o_led=0`, `o_stall=0`.
  - busy=0, pos=0, passes=0, mode=0, R=0.
  - DIV=`CLK_DIV`; divider counter = `CLK_DIV`-1.
- Reset takes effect immediately, including mid-walk and with a request pending. Any un-acked request is dropped.
- Start accepted at edge T:
  - From T+1: busy=1, pos=0, passes=R (or 1), `o_led[0]=1`.
  - First step occurs at T+DIV.
- ABORT accepted at edge T: at T+1, busy=0, pos=0, passes=0, `o_led=0`. CTRL and DIV are retained.
- `o_ack` and `o_data` are registered and change together. `o_data` holds its last value when `o_ack` is 0.
- STATUS reads reflect the state as of the acceptance edge.
- Position 0 and N-1 are each shown for only one period per turn; there is no doubled endpoint.
- CONTINUOUS wraps N-2 → ... → 0 → 1 with no endpoint hold. Passes reads 0 in this mode.
- The one-way pass boundary steps N-1 → 0. Passes decrements at every pass boundary.
- The last step of the last pass drops busy on the same edge. The slave is writable (unstalled) from the following cycle.
- A start write presented on the cycle busy is still 1 stalls. It is accepted once busy falls.
- DIV writes while idle take effect for the next start only.

## Test plan
- NLEDS=4, DIV=3, CTRL=0x001 accepted at T → `o_led` sequence 1,2,4,8,4,2,1, each held 3 cycles; busy T+1..T+21; idle with `o_led=0` at T+22; ack at T+1.
- NLEDS=4, DIV=2, CTRL=0x102 (one-way, R=2) → 1,2,4,8,1,2,4,8, each 2 cycles. STATUS passes reads 2 then 1, then 0 after 16 cycles.
- CTRL write while busy → `o_stall=1` and no ack until the walk ends. The write is accepted on the first idle cycle and the new walk starts; a STATUS read during the stall is acked next cycle.
- CONTINUOUS (CTRL=0x200), DIV=1, NLEDS=3 → 1,2,4,2,1,2,4... for 40 cycles; ABORT accepted → `o_led=0` and busy=0 next cycle, ack same cycle.
- DIV write of 0 → DIV readback 1; walk steps every cycle. CTRL write with R=0 → behaves as R=1.
- Reset asserted mid-walk (asynchronous, between edges) → `o_led`, `o_ack` and busy go 0 immediately. DIV readback after release = `CLK_DIV`.
